// File: rtl/neuron_accumulator.sv
// FP16 running-sum accumulator fed by multiplier product pulses.
// Multicycle align/add/normalize datapath; emits the sum every N_TERMS products.
module neuron_accumulator #(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_Value,
  input  logic        in_En,
  output logic [15:0] out_Sum,
  output logic        out_Ready,
  output logic        out_Busy,
  output logic        out_Overrun
);

  typedef enum logic [1:0] {StIdle, StAlign, StAdd, StNorm} state_e;

  state_e             r_state;
  logic [15:0]        r_acc;
  logic [15:0]        r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_sub;
  logic [4:0]         r_exp;
  logic [13:0]        r_mant_a;
  logic [13:0]        r_mant_b;
  logic [14:0]        r_sum;
  logic               r_sum_sign;
  logic [4:0]         r_sum_exp;

  // Unpack with subnormal flush and exp=31 clamped to max finite.
  logic [4:0]  w_a_exp, w_o_exp, w_big_exp, w_small_exp, w_diff;
  logic [9:0]  w_a_frac, w_o_frac;
  logic [13:0] w_a_mant, w_o_mant, w_big_mant, w_small_mant, w_small_sh;
  logic        w_op_big, w_big_sign, w_small_sign;

  always_comb begin
    w_a_exp  = r_acc[14:10];
    w_a_frac = r_acc[9:0];
    if (w_a_exp == 5'd31) begin
      w_a_exp  = 5'd30;
      w_a_frac = 10'h3FF;
    end else if (w_a_exp == 5'd0) begin
      w_a_frac = 10'h000;
    end
    w_o_exp  = r_op[14:10];
    w_o_frac = r_op[9:0];
    if (w_o_exp == 5'd31) begin
      w_o_exp  = 5'd30;
      w_o_frac = 10'h3FF;
    end else if (w_o_exp == 5'd0) begin
      w_o_frac = 10'h000;
    end
    w_a_mant = {(w_a_exp != 5'd0), w_a_frac, 3'b000};
    w_o_mant = {(w_o_exp != 5'd0), w_o_frac, 3'b000};
    w_op_big = {w_o_exp, w_o_frac} > {w_a_exp, w_a_frac};
    if (w_op_big) begin
      w_big_exp    = w_o_exp;
      w_big_mant   = w_o_mant;
      w_big_sign   = r_op[15];
      w_small_exp  = w_a_exp;
      w_small_mant = w_a_mant;
      w_small_sign = r_acc[15];
    end else begin
      w_big_exp    = w_a_exp;
      w_big_mant   = w_a_mant;
      w_big_sign   = r_acc[15];
      w_small_exp  = w_o_exp;
      w_small_mant = w_o_mant;
      w_small_sign = r_op[15];
    end
    w_diff     = w_big_exp - w_small_exp;
    w_small_sh = (w_diff >= 5'd14) ? 14'd0 : (w_small_mant >> w_diff);
  end

  // Normalize: shift leading one to bit 14, keep 10 fraction bits, drop the rest.
  logic [3:0]         w_lz;
  logic [10:0]        w_norm;
  logic signed [6:0]  w_exp_n;
  logic [15:0]        w_result;

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (r_sum[i]) w_lz = 4'(14 - i);
    end
    w_norm  = 11'((r_sum << w_lz) >> 4);
    w_exp_n = $signed({2'b00, r_sum_exp}) + 7'sd1 - $signed({3'b000, w_lz});
    if (!w_norm[10] || (w_exp_n < 7'sd1)) begin
      w_result = 16'h0000;
    end else if (w_exp_n > 7'sd30) begin
      w_result = {r_sum_sign, 15'h7BFF};
    end else begin
      w_result = {r_sum_sign, w_exp_n[4:0], w_norm[9:0]};
    end
  end

  assign out_Busy = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= 16'h0000;
      r_op        <= 16'h0000;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= 5'd0;
      r_mant_a    <= 14'd0;
      r_mant_b    <= 14'd0;
      r_sum       <= 15'd0;
      r_sum_sign  <= 1'b0;
      r_sum_exp   <= 5'd0;
      out_Sum     <= 16'h0000;
      out_Ready   <= 1'b0;
      out_Overrun <= 1'b0;
    end else begin
      out_Ready <= 1'b0;
      if (in_En && (r_state != StIdle)) out_Overrun <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (in_En) begin
            r_op    <= in_Value;
            r_state <= StAlign;
          end
        end
        StAlign: begin
          r_sign   <= w_big_sign;
          r_sub    <= w_big_sign ^ w_small_sign;
          r_exp    <= w_big_exp;
          r_mant_a <= w_big_mant;
          r_mant_b <= w_small_sh;
          r_state  <= StAdd;
        end
        StAdd: begin
          r_sum      <= r_sub ? ({1'b0, r_mant_a} - {1'b0, r_mant_b})
                              : ({1'b0, r_mant_a} + {1'b0, r_mant_b});
          r_sum_sign <= r_sign;
          r_sum_exp  <= r_exp;
          r_state    <= StNorm;
        end
        StNorm: begin
          if (r_cnt == CNT_W'(N_TERMS - 1)) begin
            out_Sum   <= w_result;
            out_Ready <= 1'b1;
            r_acc     <= 16'h0000;
            r_cnt     <= '0;
          end else begin
            r_acc <= w_result;
            r_cnt <= r_cnt + 1'b1;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: table of 8-term sums plus overrun/reset sequences.
module tb_neuron_accumulator;

  logic        clk;
  logic        rst;
  logic [15:0] in_Value;
  logic        in_En;
  logic [15:0] out_Sum;
  logic        out_Ready;
  logic        out_Busy;
  logic        out_Overrun;

  int total;
  int bad;

  neuron_accumulator #(
    .N_TERMS(8),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_Value   (in_Value),
    .in_En      (in_En),
    .out_Sum    (out_Sum),
    .out_Ready  (out_Ready),
    .out_Busy   (out_Busy),
    .out_Overrun(out_Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic [7:0][15:0] terms;  // first term in the leftmost slot
    logic [15:0]      exp_sum;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One term: accept at edge E, sample out_Ready just after E+3.
  task automatic send(input logic [15:0] v, output logic rdy);
    @(negedge clk);
    in_Value = v;
    in_En    = 1'b1;
    @(posedge clk);
    #1;
    in_En    = 1'b0;
    in_Value = 16'hA5A5;
    check("busy_after_accept", {15'd0, out_Busy}, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    rdy = out_Ready;
    check("idle_after_norm", {15'd0, out_Busy}, 16'd0);
  endtask

  logic rdy;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_En    = 1'b0;
    in_Value = 16'h0000;

    vecs[0]  = '{"ones_x8",     {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                                 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h4800};
    vecs[1]  = '{"ones_fresh",  {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                                 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h4800};
    vecs[2]  = '{"mixed",       {16'h3E00, 16'h3800, 16'hBC00, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h3C00};
    vecs[3]  = '{"cancel",      {16'h3C00, 16'hBC00, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000};
    vecs[4]  = '{"sat_pos",     {16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h7BFF};
    vecs[5]  = '{"sat_neg",     {16'hFBFF, 16'hFBFF, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hFBFF};
    vecs[6]  = '{"shift_out",   {16'h6400, 16'h0400, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h6400};
    vecs[7]  = '{"neg_result",  {16'h4000, 16'hC200, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hBC00};
    vecs[8]  = '{"exp31_clamp", {16'h7C00, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h7BFF};
    vecs[9]  = '{"subn_flush",  {16'h0001, 16'h3C00, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h3C00};
    vecs[10] = '{"lsb_keep",    {16'h3C00, 16'h1400, 16'h1000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h3C01};

    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", out_Sum, 16'h0000);
    check("rst_ready", {15'd0, out_Ready}, 16'd0);
    check("rst_busy", {15'd0, out_Busy}, 16'd0);
    check("rst_overrun", {15'd0, out_Overrun}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < 8; i++) begin
        send(vecs[k].terms[7-i], rdy);
        if (i < 7) begin
          check({vecs[k].name, "_early_ready"}, {15'd0, rdy}, 16'd0);
        end else begin
          check({vecs[k].name, "_ready"}, {15'd0, rdy}, 16'd1);
          check({vecs[k].name, "_sum"}, out_Sum, vecs[k].exp_sum);
        end
      end
      @(posedge clk);
      #1;
      check({vecs[k].name, "_ready_pulse"}, {15'd0, out_Ready}, 16'd0);
      check({vecs[k].name, "_sum_hold"}, out_Sum, vecs[k].exp_sum);
    end

    // Overrun: in_En held into the ALIGN edge must be dropped.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ovr_clear", {15'd0, out_Overrun}, 16'd0);
    @(negedge clk);
    in_Value = 16'h3C00;
    in_En    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_Value = 16'h4000;
    @(posedge clk);
    #1;
    in_En = 1'b0;
    check("ovr_set", {15'd0, out_Overrun}, 16'd1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      send(16'h0000, rdy);
      if (i < 6) check("ovr_early_ready", {15'd0, rdy}, 16'd0);
    end
    check("ovr_ready", {15'd0, rdy}, 16'd1);
    check("ovr_sum", out_Sum, 16'h3C00);
    check("ovr_sticky", {15'd0, out_Overrun}, 16'd1);

    // Reset during ADD after three accumulated terms.
    for (int i = 0; i < 3; i++) send(16'h3C00, rdy);
    @(negedge clk);
    in_Value = 16'h3C00;
    in_En    = 1'b1;
    @(posedge clk);
    #1;
    in_En = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("radd_sum", out_Sum, 16'h0000);
    check("radd_ready", {15'd0, out_Ready}, 16'd0);
    check("radd_busy", {15'd0, out_Busy}, 16'd0);
    check("radd_overrun", {15'd0, out_Overrun}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(16'h3C00, rdy);
      if (i < 7) check("radd_early_ready", {15'd0, rdy}, 16'd0);
    end
    check("radd_ready_final", {15'd0, rdy}, 16'd1);
    check("radd_sum_final", out_Sum, 16'h4800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Downstream consumer of the half-precision multiplier. Takes each product pulse (multiplier out_Out qualified by out_Ready) and adds it into a running FP16 sum.
- After N_TERMS products it emits the neuron's weighted sum and clears itself for the next neuron.
- The adder is a multicycle FSM, so the datapath has one align, one add and one normalize stage, with no pipelining.

Parameters:
- N_TERMS, 8, number of products summed per output (1..255).
- CNT_W, 8, width of the term counter; must satisfy 2^CNT_W > N_TERMS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_Value  input  16  FP16 operand: sign[15], exp[14:10] (bias 15), frac[9:0]; driven from the multiplier's out_Out.
- in_En  input  1  operand-valid strobe; driven from the multiplier's out_Ready.
- out_Sum  output  16  FP16 accumulated result; holds its value until the next completion.
- out_Ready  output  1  one-cycle pulse when out_Sum is updated.
- out_Busy  output  1  high while an addition is in flight; in_En is not accepted while high.
- out_Overrun  output  1  sticky flag set when in_En is asserted while busy; cleared only by rst.

Behaviour:
- Reset (rst sampled high at posedge clk):
  - state=IDLE, accumulator=+0 (0x0000), term count=0.
  - out_Sum=0x0000, out_Ready=0, out_Busy=0, out_Overrun=0.
  - Reset takes effect mid-operation: any in-flight term is discarded.
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> IDLE.
  - IDLE: when in_En=1, capture in_Value into the operand register and go to ALIGN. When in_En=0, stay.
  - ALIGN: unpack accumulator and operand, with hidden bit = 1 when exp != 0. Swap so the larger magnitude is first. Right-shift the smaller 14-bit mantissa (hidden + 10 frac + 3 extra LSBs) by the exponent difference. A difference >= 14 zeroes the smaller mantissa.
  - ADD: 15-bit add, or subtract when signs differ. Result sign = sign of the larger magnitude.
  - NORM: single-cycle leading-one detect and shift, with exponent adjust.
    - Truncate extra bits; no rounding.
    - Write the result to the accumulator and increment the term count.
    - Go to IDLE.
- Latency: accept edge E; accumulator updated at edge E+3; IDLE again after edge E+3. The next operand can be accepted at edge E+4.
- out_Busy = (state != IDLE), combinationally derived from the registered state.
- in_En high while out_Busy=1: the operand is dropped, out_Overrun is set, and the accumulator is unaffected.
- Completion: at the NORM edge where the count reaches N_TERMS:
  - out_Sum <= result and out_Ready <= 1 for exactly one cycle.
  - Accumulator <= +0 and count <= 0, all in that same edge.
- Arithmetic rules:
  - Operand or result with exp=0 is treated as zero (subnormals flushed); a zero result is encoded as +0 (0x0000).
  - Exact cancellation gives 0x0000.
  - Exponent overflow (>30) saturates to max finite magnitude (0x7BFF or 0xFBFF, keeping the sign).
  - exp=31 inputs are treated as max finite (no Inf/NaN propagation).
- in_Value is sampled only at the accept edge; it may change afterwards.

Test Plan:
- Reset then eight in_En pulses of 0x3C00 (1.0), spaced 4 cycles apart. Required: out_Ready pulses once, 3 edges after the 8th accept, with out_Sum=0x4800 (8.0). The 9th term starts a fresh sum.
- Terms 0x3E00 (1.5), 0x3800 (0.5), 0xBC00 (-1.0), then five of 0x0000 (N_TERMS=8). Required: out_Sum=0x3C00.
- 0x3C00 followed by 0xBC00, padded with zeros. Required: out_Sum=0x0000 (no negative zero).
- 0x7BFF twice, padded with zeros. Required: out_Sum=0x7BFF (saturation); similarly 0xFBFF twice gives 0xFBFF.
- 0x6400 (1024) plus 0x0400 (2^-14), padded with zeros. Required: out_Sum=0x6400, the small term fully shifted out.
- Assert in_En on the cycle after an accept. Required: operand ignored, out_Overrun=1 and stays high, final sum excludes it. Assert rst during ADD: next cycle all outputs are 0 and count restarts.
